// File: rtl/key_entry_buffer_if.sv
// ---------------------------------------------------------------------------
// key_entry_buffer_if
//
// Purpose: bundles the keypad-side strobes and the entry-buffer results into
// one interface, so the keypad decoder, the entry buffer and the alarm/time
// registers all share a single connection.
//
// Parameters:
//   DIGITS   number of digit slots held by the buffer
//   DIGIT_W  bits per digit
//
// Signals:
//   key_valid      keypad -> buffer   1-cycle strobe, key holds a new keypress
//   key            keypad -> buffer   key code, 0-9 are digits
//   key_clear      keypad -> buffer   1-cycle strobe, discard the entry
//   key_bksp       keypad -> buffer   1-cycle strobe, delete the last digit
//   key_enter      keypad -> buffer   1-cycle strobe, commit the entry
//   key_buffer     buffer -> consumer digit 0 (LS slice) is the last digit typed
//   digit_count    buffer -> consumer number of valid digits, 0..DIGITS
//   entry_busy     buffer -> consumer high while an entry is in progress
//   entry_done     buffer -> consumer 1-cycle pulse, commit accepted
//   entry_timeout  buffer -> consumer 1-cycle pulse, entry abandoned by timeout
//   entry_err      buffer -> consumer 1-cycle pulse, commit rejected
//
// Modports:
//   master  keypad/test side (drives the strobes, observes the results)
//   slave   the entry buffer itself
// ---------------------------------------------------------------------------
interface key_entry_buffer_if #(
    parameter int DIGITS  = 4,
    parameter int DIGIT_W = 4
);

    localparam int CNT_W = $clog2(DIGITS + 1);

    logic                      key_valid;
    logic [DIGIT_W-1:0]        key;
    logic                      key_clear;
    logic                      key_bksp;
    logic                      key_enter;
    logic [DIGITS*DIGIT_W-1:0] key_buffer;
    logic [CNT_W-1:0]          digit_count;
    logic                      entry_busy;
    logic                      entry_done;
    logic                      entry_timeout;
    logic                      entry_err;

    modport master (
        output key_valid, key, key_clear, key_bksp, key_enter,
        input  key_buffer, digit_count, entry_busy, entry_done,
               entry_timeout, entry_err
    );

    modport slave (
        input  key_valid, key, key_clear, key_bksp, key_enter,
        output key_buffer, digit_count, entry_busy, entry_done,
               entry_timeout, entry_err
    );

endinterface

// File: rtl/key_entry_buffer.sv
// ---------------------------------------------------------------------------
// key_entry_buffer
//
// Purpose: keypad digit-entry buffer for alarm/time setting. Decoded digits
// shift in from the right (newest digit in the LS slice); backspace, clear,
// enter-commit and an inactivity timeout are supported. Downstream alarm/time
// registers load key_buffer when entry_done pulses.
//
// Parameters:
//   DIGITS       number of digit slots (>= 2)
//   DIGIT_W      bits per digit (>= 4 so codes 0-9 fit)
//   TIMEOUT_CYC  idle clock cycles in ENTRY before the entry is abandoned (>= 2)
//
// Ports:
//   clock    in  single clock, all logic on posedge
//   reset_n  in  asynchronous active-low reset
//   kbd      key_entry_buffer_if.slave (strobes in, buffer/count/pulses out;
//            the interface must use the same DIGITS/DIGIT_W)
//
// Optional feature (macro TIME_RANGE_CHECK_EN, requires DIGITS == 4):
//   enter is only accepted when the buffer holds a full, valid HH:MM
//   (hour <= 23, minute <= 59); otherwise entry_err pulses and the entry
//   stays open. Without the macro entry_err is tied low and enter in ENTRY
//   always commits.
//
// Event resolution: one event per cycle, clear > enter > bksp > digit.
// In IDLE only clear and digit are recognised; enter/bksp there are treated
// as absent, so a digit arriving with them still opens an entry.
// ---------------------------------------------------------------------------
module key_entry_buffer #(
    parameter int DIGITS      = 4,
    parameter int DIGIT_W     = 4,
    parameter int TIMEOUT_CYC = 2560
) (
    input logic               clock,
    input logic               reset_n,
    key_entry_buffer_if.slave kbd
);

    localparam int CNT_W = $clog2(DIGITS + 1);
    localparam int TMR_W = $clog2(TIMEOUT_CYC);
    localparam int BUF_W = DIGITS * DIGIT_W;

    localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(DIGITS);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [DIGIT_W-1:0] KEY_MAX  = DIGIT_W'(9);

    typedef enum logic {
        IDLE  = 1'b0,
        ENTRY = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [BUF_W-1:0] keyBuf_q, keyBuf_d;
    logic [CNT_W-1:0] digitCnt_q, digitCnt_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             done_q, done_d;
    logic             timeout_q, timeout_d;
`ifdef TIME_RANGE_CHECK_EN
    logic             err_q, err_d;
    logic             timeValid;
`endif

    logic             isDigit;
    logic [BUF_W-1:0] bufShiftIn;
    logic [BUF_W-1:0] bufShiftOut;
    logic [BUF_W-1:0] bufFirst;

    // A keypress only counts as a digit when the code is 0-9; other codes
    // are dropped without touching state or timer.
    assign isDigit = kbd.key_valid && (kbd.key <= KEY_MAX);

    // Candidate buffer values: new digit enters on the right (oldest falls
    // off the left), backspace shifts right with zero fill, and the first
    // digit of an entry replaces whatever value was left from before.
    assign bufShiftIn  = {keyBuf_q[BUF_W-DIGIT_W-1:0], kbd.key};
    assign bufShiftOut = {{DIGIT_W{1'b0}}, keyBuf_q[BUF_W-1:DIGIT_W]};
    assign bufFirst    = {{(BUF_W-DIGIT_W){1'b0}}, kbd.key};

`ifdef TIME_RANGE_CHECK_EN
    // HH:MM check on the four held digits. Only digits 0-9 can ever be
    // shifted in, so the minute units digit is always in range and the
    // checks reduce to the tens digits.
    logic [DIGIT_W-1:0] hourTens, hourUnits, minTens;
    assign hourTens  = keyBuf_q[4*DIGIT_W-1:3*DIGIT_W];
    assign hourUnits = keyBuf_q[3*DIGIT_W-1:2*DIGIT_W];
    assign minTens   = keyBuf_q[2*DIGIT_W-1:DIGIT_W];
    assign timeValid = (digitCnt_q == CNT_FULL)
                     && ((hourTens < DIGIT_W'(2))
                         || ((hourTens == DIGIT_W'(2)) && (hourUnits <= DIGIT_W'(3))))
                     && (minTens <= DIGIT_W'(5));
`endif

    // State register: everything observable is registered here, so each
    // event shows on the outputs one clock after its strobe is sampled.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            keyBuf_q   <= '0;
            digitCnt_q <= '0;
            timer_q    <= '0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
`ifdef TIME_RANGE_CHECK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            keyBuf_q   <= keyBuf_d;
            digitCnt_q <= digitCnt_d;
            timer_q    <= timer_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
`ifdef TIME_RANGE_CHECK_EN
            err_q      <= err_d;
`endif
        end
    end

    // Next-state logic. The timer counts idle cycles in ENTRY; any accepted
    // event clears it, and an event on the final timer cycle beats the
    // timeout because it is checked first.
    always_comb begin
        state_d    = state_q;
        keyBuf_d   = keyBuf_q;
        digitCnt_d = digitCnt_q;
        timer_d    = timer_q;
        done_d     = 1'b0;
        timeout_d  = 1'b0;
`ifdef TIME_RANGE_CHECK_EN
        err_d      = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (kbd.key_clear) begin
                    keyBuf_d   = '0;
                    digitCnt_d = '0;
                end else if (isDigit) begin
                    keyBuf_d   = bufFirst;
                    digitCnt_d = CNT_ONE;
                    state_d    = ENTRY;
                end
            end

            ENTRY: begin
                timer_d = timer_q + 1'b1;
                if (kbd.key_clear) begin
                    keyBuf_d   = '0;
                    digitCnt_d = '0;
                    timer_d    = '0;
                    state_d    = IDLE;
                end else if (kbd.key_enter) begin
                    timer_d = '0;
`ifdef TIME_RANGE_CHECK_EN
                    if (timeValid) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        err_d   = 1'b1;
                    end
`else
                    done_d  = 1'b1;
                    state_d = IDLE;
`endif
                end else if (kbd.key_bksp) begin
                    keyBuf_d   = bufShiftOut;
                    digitCnt_d = digitCnt_q - 1'b1;
                    timer_d    = '0;
                    if (digitCnt_q == CNT_ONE) begin
                        state_d = IDLE;
                    end
                end else if (isDigit) begin
                    keyBuf_d = bufShiftIn;
                    timer_d  = '0;
                    if (digitCnt_q != CNT_FULL) begin
                        digitCnt_d = digitCnt_q + 1'b1;
                    end
                end else if (timer_q == TMR_LAST) begin
                    keyBuf_d   = '0;
                    digitCnt_d = '0;
                    timer_d    = '0;
                    timeout_d  = 1'b1;
                    state_d    = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign kbd.key_buffer    = keyBuf_q;
    assign kbd.digit_count   = digitCnt_q;
    assign kbd.entry_busy    = (state_q == ENTRY);
    assign kbd.entry_done    = done_q;
    assign kbd.entry_timeout = timeout_q;
`ifdef TIME_RANGE_CHECK_EN
    assign kbd.entry_err     = err_q;
`else
    assign kbd.entry_err     = 1'b0;
`endif

endmodule

// File: tb/tb_key_entry_buffer.sv
// ---------------------------------------------------------------------------
// tb_key_entry_buffer
//
// Drives key_entry_buffer through directed keypad sequences and a long run
// of random keypresses. A reference model keeps the entry as a queue of
// typed digits and pushes the expected output snapshot for every clock into
// a scoreboard; a separate monitor pops and compares on each falling edge.
// ---------------------------------------------------------------------------
module tb_key_entry_buffer;

    localparam int DIGITS      = 4;
    localparam int DIGIT_W     = 4;
    localparam int TIMEOUT_CYC = 24;
    localparam int CNT_W       = $clog2(DIGITS + 1);
    localparam int BUF_W       = DIGITS * DIGIT_W;

    typedef struct packed {
        logic [BUF_W-1:0] buffer;
        logic [CNT_W-1:0] count;
        logic             busy;
        logic             done;
        logic             timeout;
        logic             err;
    } snap_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    int compared   = 0;
    int mismatched = 0;

    snap_t expQ[$];
    snap_t monExp;

    // Reference model state: digits typed so far, oldest first.
    int digitsQ[$];
    bit mBusy;
    int waited;

    always #5 clock = ~clock;

    key_entry_buffer_if #(.DIGITS(DIGITS), .DIGIT_W(DIGIT_W)) kbd ();

    key_entry_buffer #(
        .DIGITS     (DIGITS),
        .DIGIT_W    (DIGIT_W),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .kbd    (kbd)
    );

    // Compare every output field against an expected snapshot.
    task automatic checkOutput(input string tag, input snap_t e);
        snap_t a;
        a.buffer  = kbd.key_buffer;
        a.count   = kbd.digit_count;
        a.busy    = kbd.entry_busy;
        a.done    = kbd.entry_done;
        a.timeout = kbd.entry_timeout;
        a.err     = kbd.entry_err;
        compared++;
        if (a.buffer !== e.buffer) begin
            mismatched++;
            $display("[TB] FAIL %s key_buffer got=%h want=%h @%0t", tag, a.buffer, e.buffer, $time);
        end
        compared++;
        if (a.count !== e.count) begin
            mismatched++;
            $display("[TB] FAIL %s digit_count got=%0d want=%0d @%0t", tag, a.count, e.count, $time);
        end
        compared++;
        if ({a.busy, a.done, a.timeout, a.err} !== {e.busy, e.done, e.timeout, e.err}) begin
            mismatched++;
            $display("[TB] FAIL %s busy/done/timeout/err got=%b%b%b%b want=%b%b%b%b @%0t",
                     tag, a.busy, a.done, a.timeout, a.err,
                     e.busy, e.done, e.timeout, e.err, $time);
        end
    endtask

    function automatic snap_t modelSnap(bit done, bit timeout, bit err);
        snap_t s;
        int    n;
        s.buffer = '0;
        n = digitsQ.size();
        for (int i = 0; i < n; i++) begin
            s.buffer[i*DIGIT_W +: DIGIT_W] = DIGIT_W'(digitsQ[n-1-i]);
        end
        s.count   = CNT_W'(n);
        s.busy    = mBusy;
        s.done    = done;
        s.timeout = timeout;
        s.err     = err;
        return s;
    endfunction

    function automatic bit modelTimeOk();
        if (digitsQ.size() != 4) return 1'b0;
        return ((digitsQ[0] * 10 + digitsQ[1]) <= 23) && ((digitsQ[2] * 10 + digitsQ[3]) <= 59);
    endfunction

    function automatic void modelReset();
        digitsQ.delete();
        mBusy  = 1'b0;
        waited = 0;
    endfunction

    // One clock of behaviour: resolve the winning event, update the digit
    // list, and return the outputs expected after this edge.
    function automatic snap_t modelStep(bit v, int k, bit c, bit b, bit e);
        bit isDigit = v && (k <= 9);
        bit done = 1'b0, tmo = 1'b0, err = 1'b0;
        if (!mBusy) begin
            if (c) begin
                digitsQ.delete();
            end else if (isDigit) begin
                digitsQ.delete();
                digitsQ.push_back(k);
                mBusy  = 1'b1;
                waited = 0;
            end
        end else begin
            if (c) begin
                digitsQ.delete();
                mBusy = 1'b0;
            end else if (e) begin
                waited = 0;
`ifdef TIME_RANGE_CHECK_EN
                if (modelTimeOk()) begin
                    done  = 1'b1;
                    mBusy = 1'b0;
                end else begin
                    err = 1'b1;
                end
`else
                done  = 1'b1;
                mBusy = 1'b0;
`endif
            end else if (b) begin
                void'(digitsQ.pop_back());
                waited = 0;
                if (digitsQ.size() == 0) mBusy = 1'b0;
            end else if (isDigit) begin
                digitsQ.push_back(k);
                if (digitsQ.size() > DIGITS) void'(digitsQ.pop_front());
                waited = 0;
            end else begin
                waited++;
                if (waited == TIMEOUT_CYC) begin
                    digitsQ.delete();
                    mBusy = 1'b0;
                    tmo   = 1'b1;
                end
            end
        end
        return modelSnap(done, tmo, err);
    endfunction

    // Drive one cycle of keypad inputs and queue the expected response.
    task automatic applyStimulus(input bit v, input int k, input bit c, input bit b, input bit e);
        @(negedge clock);
        #1;
        kbd.key_valid = v;
        kbd.key       = DIGIT_W'(k);
        kbd.key_clear = c;
        kbd.key_bksp  = b;
        kbd.key_enter = e;
        @(posedge clock);
        expQ.push_back(modelStep(v, k, c, b, e));
    endtask

    task automatic typeDigit(input int k);
        applyStimulus(1'b1, k, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    // Spot check of the outputs right after the edge that applyStimulus
    // just waited for, against hand-derived constants.
    task automatic spotCheck(input string tag, input logic [BUF_W-1:0] buffer,
                             input int count, input bit busy, input bit done, input bit tmo);
        snap_t s;
        s.buffer  = buffer;
        s.count   = CNT_W'(count);
        s.busy    = busy;
        s.done    = done;
        s.timeout = tmo;
        s.err     = 1'b0;
        #2;
        checkOutput(tag, s);
    endtask

    task automatic doReset();
        @(negedge clock);
        #1;
        reset_n       = 1'b0;
        kbd.key_valid = 1'b0;
        kbd.key_clear = 1'b0;
        kbd.key_bksp  = 1'b0;
        kbd.key_enter = 1'b0;
        modelReset();
        #1;
        checkOutput("reset_immediate", modelSnap(1'b0, 1'b0, 1'b0));
        repeat (2) @(negedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    // Monitor: compare the DUT against the oldest queued expectation.
    always @(negedge clock) begin
        if (expQ.size() > 0) begin
            monExp = expQ.pop_front();
            checkOutput("scoreboard", monExp);
        end
    end

    initial begin
        int r;
        kbd.key_valid = 1'b0;
        kbd.key       = '0;
        kbd.key_clear = 1'b0;
        kbd.key_bksp  = 1'b0;
        kbd.key_enter = 1'b0;
        modelReset();

        doReset();
        idleCycles(1);

        // T1: digits 1,2,3,0 then enter.
        typeDigit(1); typeDigit(2); typeDigit(3); typeDigit(0);
        spotCheck("t1_full", 16'h1230, 4, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1);
        spotCheck("t1_enter", 16'h1230, 4, 1'b0, 1'b1, 1'b0);
        idleCycles(1);
        spotCheck("t1_hold", 16'h1230, 4, 1'b0, 1'b0, 1'b0);

        // T2: overflow keeps the newest four digits, then backspace.
        typeDigit(1); typeDigit(2); typeDigit(3); typeDigit(4); typeDigit(5);
        spotCheck("t2_overflow", 16'h2345, 4, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);
        spotCheck("t2_bksp", 16'h0234, 3, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0);

        // T3: timeout after a lone digit, then a digit on the last cycle.
        typeDigit(7);
        idleCycles(TIMEOUT_CYC);
        spotCheck("t3_timeout", 16'h0000, 0, 1'b0, 1'b0, 1'b1);
        typeDigit(7);
        idleCycles(TIMEOUT_CYC - 1);
        typeDigit(7);
        spotCheck("t3_rescue", 16'h0077, 2, 1'b1, 1'b0, 1'b0);
        idleCycles(2);
        applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0);

        // T4: clear beats enter and digit; out-of-range key is ignored.
        typeDigit(5);
        applyStimulus(1'b1, 6, 1'b1, 1'b0, 1'b1);
        spotCheck("t4_clear_wins", 16'h0000, 0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 11, 1'b0, 1'b0, 1'b0);
        spotCheck("t4_badkey_idle", 16'h0000, 0, 1'b0, 1'b0, 1'b0);
        typeDigit(3);
        applyStimulus(1'b1, 11, 1'b0, 1'b0, 1'b0);
        spotCheck("t4_badkey_entry", 16'h0003, 1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);
        spotCheck("t4_bksp_to_idle", 16'h0000, 0, 1'b0, 1'b0, 1'b0);

`ifdef TIME_RANGE_CHECK_EN
        // T5: invalid time rejected, valid time committed.
        typeDigit(2); typeDigit(5); typeDigit(0); typeDigit(0);
        applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0);
        typeDigit(2); typeDigit(3); typeDigit(5); typeDigit(9);
        applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1);
        spotCheck("t5_commit", 16'h2359, 4, 1'b0, 1'b1, 1'b0);
`endif

        // T6: reset in the middle of an entry.
        typeDigit(4); typeDigit(8);
        doReset();
        idleCycles(TIMEOUT_CYC + 2);
        spotCheck("t6_quiet", 16'h0000, 0, 1'b0, 1'b0, 1'b0);

        // Random keypad traffic, with occasional idle bursts near the timeout.
        for (int n = 0; n < 2500; n++) begin
            r = $urandom_range(0, 99);
            if (r < 55) begin
                applyStimulus(1'b1, $urandom_range(0, 15), 1'b0, 1'b0, 1'b0);
            end else if (r < 65) begin
                applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);
            end else if (r < 72) begin
                applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1);
            end else if (r < 75) begin
                applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0);
            end else if (r < 82) begin
                applyStimulus(1'($urandom_range(0, 1)), $urandom_range(0, 15),
                              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 1)));
            end else if (r < 84) begin
                idleCycles($urandom_range(TIMEOUT_CYC - 3, TIMEOUT_CYC + 2));
            end else begin
                idleCycles(1);
            end
        end

        // Drain the scoreboard with a bounded wait.
        for (int w = 0; w < 5 && expQ.size() > 0; w++) @(negedge clock);
        #1;
        compared++;
        if (expQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL drain pending=%0d want=0", expQ.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
